// File: rtl/amp_trig_pkg.sv
// Shared types and constants for the amplifier trigger receive path.
package amp_trig_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_AMP = 2'd1,
        S_WIDTH    = 2'd2,
        S_REPORT   = 2'd3
    } state_e;

    localparam int unsigned ST_TIMEOUT   = 0;
    localparam int unsigned ST_GATE_DROP = 1;
    localparam int unsigned ST_STUCK     = 2;
    localparam int unsigned ST_OVERRUN   = 3;

    localparam int unsigned MSTR_W = 7;
    localparam int unsigned BLK_W  = 5;
    localparam int unsigned WID_W  = 8;

    function automatic logic [MSTR_W-1:0] abs_diff(input logic [MSTR_W-1:0] a,
                                                   input logic [MSTR_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/amp_trig_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
module amp_trig_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic level,
    output logic rise
);

    // bit 0 = first sync stage, bit 1 = synchronised level, bit 2 = previous level
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/amp_trig_rx.sv
// Amplifier trigger receiver: measures amp pulse delay and width against the
// trigger_in timebase and reports one result per trigger via valid/ack.
module amp_trig_rx
    import amp_trig_pkg::*;
#(
    parameter logic [BLK_W-1:0] TRIG_BLK_SIZE = 5'd20,
    parameter logic [WID_W-1:0] WIDTH_MAX     = 8'd255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger_in,
    input  logic              amp_trig_in,
    input  logic              arm_en,
    input  logic [MSTR_W-1:0] expected_delay,
    input  logic [2:0]        delay_tol,
    input  logic              meas_ack,
    output logic              meas_valid,
    output logic [MSTR_W-1:0] meas_delay,
    output logic [BLK_W-1:0]  meas_fine,
    output logic [WID_W-1:0]  meas_width,
    output logic              meas_match,
    output logic [3:0]        meas_status,
    output logic [7:0]        stray_cnt
);

    state_e            state_q, state_d;
    logic              trig_lvl, trig_rise, amp_lvl, amp_rise;
    logic [MSTR_W-1:0] mstr_q, mstr_d, mstr_inc;
    logic [BLK_W-1:0]  blk_q, blk_d, blk_inc;
    logic [WID_W-1:0]  wid_inc;
    logic              ovr_pend_q, ovr_pend_d;
    logic [MSTR_W-1:0] delay_q, delay_d;
    logic [BLK_W-1:0]  fine_q, fine_d;
    logic [WID_W-1:0]  width_q, width_d;
    logic              match_q, match_d;
    logic [3:0]        status_q, status_d;
    logic [7:0]        stray_q, stray_d;
    logic              ev_restart, ev_capture, ev_gate_drop, ev_timeout;
    logic              ev_count, ev_width_done, ev_stuck, ev_ovr;

    amp_trig_sync_edge u_sync_trig (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (trigger_in),
        .level (trig_lvl),
        .rise  (trig_rise)
    );

    amp_trig_sync_edge u_sync_amp (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (amp_trig_in),
        .level (amp_lvl),
        .rise  (amp_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ev_restart    = 1'b0;
        ev_capture    = 1'b0;
        ev_gate_drop  = 1'b0;
        ev_timeout    = 1'b0;
        ev_count      = 1'b0;
        ev_width_done = 1'b0;
        ev_stuck      = 1'b0;
        ev_ovr        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (trig_rise && arm_en) begin
                    state_d    = S_WAIT_AMP;
                    ev_restart = 1'b1;
                end
            end
            S_WAIT_AMP: begin
                if (!arm_en) begin
                    state_d = S_IDLE;
                end else if (trig_rise) begin
                    ev_restart = 1'b1;
                end else if (!trig_lvl) begin
                    state_d      = S_REPORT;
                    ev_gate_drop = 1'b1;
                end else if ((mstr_q == '1) && (blk_q == TRIG_BLK_SIZE)) begin
                    state_d    = S_REPORT;
                    ev_timeout = 1'b1;
                end else if (amp_rise) begin
                    state_d    = S_WIDTH;
                    ev_capture = 1'b1;
                end
            end
            S_WIDTH: begin
                ev_ovr = trig_rise;
                if (!arm_en) begin
                    state_d = S_IDLE;
                end else if (!amp_lvl) begin
                    state_d       = S_REPORT;
                    ev_width_done = 1'b1;
                end else begin
                    ev_count = 1'b1;
                    if (wid_inc == WIDTH_MAX) begin
                        state_d       = S_REPORT;
                        ev_width_done = 1'b1;
                        ev_stuck      = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                ev_ovr = trig_rise;
                if (meas_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        meas_valid = (state_q == S_REPORT);
    end

    // An amp edge captures the count for its own cycle, i.e. one past the registered value.
    always_comb begin
        if (blk_q == TRIG_BLK_SIZE) begin
            blk_inc  = '0;
            mstr_inc = mstr_q + MSTR_W'(1);
        end else begin
            blk_inc  = blk_q + BLK_W'(1);
            mstr_inc = mstr_q;
        end
        wid_inc = width_q + WID_W'(1);
    end

    always_comb begin
        mstr_d     = ev_restart ? '0 : mstr_inc;
        blk_d      = ev_restart ? '0 : blk_inc;
        ovr_pend_d = ovr_pend_q;
        delay_d    = delay_q;
        fine_d     = fine_q;
        width_d    = width_q;
        match_d    = match_q;
        status_d   = status_q;
        stray_d    = stray_q;

        if (ev_capture) begin
            delay_d  = mstr_inc;
            fine_d   = blk_inc;
            width_d  = WID_W'(1);
            match_d  = (abs_diff(mstr_inc, expected_delay) <= MSTR_W'(delay_tol));
            status_d = '0;
        end

        if (ev_gate_drop || ev_timeout) begin
            delay_d                = mstr_q;
            fine_d                 = blk_q;
            width_d                = '0;
            match_d                = 1'b0;
            status_d               = '0;
            status_d[ST_TIMEOUT]   = 1'b1;
            status_d[ST_GATE_DROP] = ev_gate_drop;
            status_d[ST_OVERRUN]   = ovr_pend_q;
            ovr_pend_d             = 1'b0;
        end

        if (ev_count) begin
            width_d = wid_inc;
        end

        // Overrun seen up to REPORT entry belongs to this result; later ones to the next.
        if (ev_width_done) begin
            status_d[ST_STUCK]   = ev_stuck;
            status_d[ST_OVERRUN] = ovr_pend_q | ev_ovr;
            ovr_pend_d           = 1'b0;
        end else if (ev_ovr) begin
            ovr_pend_d = 1'b1;
        end

        if (amp_rise && (state_q != S_WAIT_AMP) && (stray_q != '1)) begin
            stray_d = stray_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstr_q     <= '0;
            blk_q      <= '0;
            ovr_pend_q <= 1'b0;
            delay_q    <= '0;
            fine_q     <= '0;
            width_q    <= '0;
            match_q    <= 1'b0;
            status_q   <= '0;
            stray_q    <= '0;
        end else begin
            mstr_q     <= mstr_d;
            blk_q      <= blk_d;
            ovr_pend_q <= ovr_pend_d;
            delay_q    <= delay_d;
            fine_q     <= fine_d;
            width_q    <= width_d;
            match_q    <= match_d;
            status_q   <= status_d;
            stray_q    <= stray_d;
        end
    end

    assign meas_delay  = delay_q;
    assign meas_fine   = fine_q;
    assign meas_width  = width_q;
    assign meas_match  = match_q;
    assign meas_status = status_q;
    assign stray_cnt   = stray_q;

endmodule
